// File: rtl/fir_filter_pkg.sv
// Shared definitions for the FIR filter serial stages: default word width
// and the one-hot state codes used by the deserializer FSM.
package fir_filter_pkg;

    localparam int DEFAULT_WORD_W = 24;

    localparam logic [3:0] ST_IDLE   = 4'b0001;
    localparam logic [3:0] ST_SHIFT  = 4'b0010;
    localparam logic [3:0] ST_PARITY = 4'b0100;
    localparam logic [3:0] ST_OUT    = 4'b1000;

    typedef enum logic [3:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        PARITY = ST_PARITY,
        OUT    = ST_OUT
    } deser_state_t;

endpackage

// File: rtl/deserializer_fsm.sv
// Serial-to-parallel deserializer: collects LSB-first bits into LENGTH-bit
// words under a valid/ready handshake and holds each word until consumed.
// Optional build macro DESER_PARITY_EN adds a trailing even-parity bit per
// word and reports its check result on o_parity_err.
module deserializer_fsm
    import fir_filter_pkg::*;
#(
    parameter int LENGTH = DEFAULT_WORD_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_ready,
    output logic              o_parity_err
);

    localparam int CNT_W = $clog2(LENGTH + 1);

    deser_state_t      state;
    logic [CNT_W-1:0]  count;
    logic [LENGTH-1:0] shift_reg;
    logic [LENGTH-1:0] shift_next;
    logic              accept;
    logic              transfer;
    logic              last_bit;

    // New bits enter at the top so the first bit received ends up in bit 0.
    assign shift_next = {i_din, shift_reg[LENGTH-1:1]};
    assign accept     = i_en && i_din_valid && o_ready;
    assign transfer   = i_en && o_dout_valid && i_ready;
    assign last_bit   = (count == CNT_W'(LENGTH - 1));

    // Ready is a pure state decode, forced low while reset is asserted.
    assign o_ready = !i_rst && (state != OUT);

`ifdef DESER_PARITY_EN
    logic parity_err;
    assign o_parity_err = parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    // Control FSM, bit counter, shift register and registered word outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            count        <= '0;
            shift_reg    <= '0;
            ov_dout      <= '0;
            o_dout_valid <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else if (i_en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= shift_next;
                        count     <= CNT_W'(1);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        shift_reg <= shift_next;
                        if (last_bit) begin
                            count <= '0;
`ifdef DESER_PARITY_EN
                            state <= PARITY;
`else
                            ov_dout      <= shift_next;
                            o_dout_valid <= 1'b1;
                            state        <= OUT;
`endif
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
`ifdef DESER_PARITY_EN
                    // Shift register already holds the full word; this
                    // accept carries only the even-parity bit.
                    if (accept) begin
                        ov_dout      <= shift_reg;
                        parity_err   <= (^shift_reg) ^ i_din;
                        o_dout_valid <= 1'b1;
                        state        <= OUT;
                    end
`else
                    state <= IDLE;
`endif
                end
                OUT: begin
                    if (transfer) begin
                        o_dout_valid <= 1'b0;
`ifdef DESER_PARITY_EN
                        parity_err   <= 1'b0;
`endif
                        state        <= IDLE;
                    end
                end
                default: begin
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deserializer_fsm.sv
// Self-checking bench for deserializer_fsm: vector table, hand-written
// reset/enable sequences and randomized words, all checked cycle by cycle
// against a word-level reference model.
module tb_deserializer_fsm;

    localparam int L = 24;
`ifdef DESER_PARITY_EN
    localparam int NBITS = L + 1;
`else
    localparam int NBITS = L;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_en;
    logic         i_din;
    logic         i_din_valid;
    logic         i_ready;
    logic         o_ready;
    logic [L-1:0] ov_dout;
    logic         o_dout_valid;
    logic         o_parity_err;

    int tests = 0;
    int fails = 0;

    // Reference model state: bits collected so far, held word, flags.
    logic [L-1:0] m_acc;
    logic [L-1:0] m_dout;
    int           m_cnt;
    logic         m_valid;
    logic         m_perr;
    logic         m_accepted;

    typedef struct {
        logic [L-1:0] word;
        logic         par;
        int           duty;
        int           rdelay;
        int           en_at;
        logic         en_out;
        logic [L-1:0] exp_dout;
        logic         exp_perr;
    } vec_t;

    vec_t vecs[$];

    deserializer_fsm #(.LENGTH(L)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_din        (i_din),
        .i_din_valid  (i_din_valid),
        .o_ready      (o_ready),
        .ov_dout      (ov_dout),
        .o_dout_valid (o_dout_valid),
        .i_ready      (i_ready),
        .o_parity_err (o_parity_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkw(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = '0; m_dout = '0; m_cnt = 0;
        m_valid = 1'b0; m_perr = 1'b0; m_accepted = 1'b0;
    endtask

    // One clock edge of behaviour: a held word blocks input until taken.
    task automatic model_edge();
        m_accepted = 1'b0;
        if (i_en) begin
            if (m_valid) begin
                if (i_ready) begin
                    m_valid = 1'b0;
                    m_perr  = 1'b0;
                end
            end else if (i_din_valid) begin
                m_accepted = 1'b1;
                if (m_cnt < L) begin
                    m_acc[m_cnt] = i_din;
                    m_cnt++;
                    if (m_cnt == NBITS) begin
                        m_dout = m_acc; m_valid = 1'b1; m_cnt = 0; m_acc = '0;
                    end
                end else begin
                    m_dout  = m_acc;
                    m_perr  = (^m_acc) ^ i_din;
                    m_valid = 1'b1; m_cnt = 0; m_acc = '0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        model_edge();
        #1;
        checkb("ready", o_ready, !m_valid);
        checkb("valid", o_dout_valid, m_valid);
        checkw("dout", ov_dout, m_dout);
        checkb("parity_err", o_parity_err, m_perr);
    endtask

    // Feed n bits of a word back to back (used for the reset scenarios).
    task automatic feed_bits(input logic [L-1:0] word, input int n);
        for (int b = 0; b < n; b++) begin
            i_din       = (b < L) ? word[b] : 1'b0;
            i_din_valid = 1'b1;
            cycle();
        end
        i_din_valid = 1'b0;
    endtask

    // Async reset pulse placed between clock edges; held across one edge.
    task automatic reset_pulse();
        #3 i_rst = 1'b1;
        #1;
        model_reset();
        checkb("rst_ready", o_ready, 1'b0);
        checkb("rst_valid", o_dout_valid, 1'b0);
        checkw("rst_dout", ov_dout, '0);
        checkb("rst_perr", o_parity_err, 1'b0);
        i_din_valid = 1'b1;
        i_din       = 1'b1;
        @(posedge i_clk);
        #1;
        checkb("rst_no_capture_ready", o_ready, 1'b0);
        checkb("rst_no_capture_valid", o_dout_valid, 1'b0);
        #2 i_rst = 1'b0;
        i_din_valid = 1'b0;
    endtask

    task automatic send_word(input vec_t v);
        int     b = 0;
        int     budget = 0;
        logic   dropped = 1'b0;
        while (b < NBITS && budget < 2000) begin
            if (b == v.en_at && !dropped) begin
                dropped = 1'b1;
                i_en = 1'b0;
                repeat (5) begin
                    i_din = 1'($urandom_range(1));
                    i_din_valid = 1'b1;
                    cycle();
                end
                i_en = 1'b1;
            end
            i_din       = (b < L) ? v.word[b] : v.par;
            i_din_valid = 1'($urandom_range(99) < v.duty);
            i_ready     = 1'($urandom_range(1));
            cycle();
            if (m_accepted) begin
                b++;
                if (b == NBITS) checkb("latency", o_dout_valid, 1'b1);
            end
            budget++;
        end
        if (b < NBITS) checkb("bit_budget_expired", 1'b0, 1'b1);
        i_din_valid = 1'b1;
        i_ready     = 1'b0;
        if (v.en_out) begin
            i_en    = 1'b0;
            i_ready = 1'b1;
            repeat (5) begin
                i_din = 1'($urandom_range(1));
                cycle();
                checkw("en_out_dout", ov_dout, v.exp_dout);
            end
            i_en    = 1'b1;
            i_ready = 1'b0;
        end
        repeat (v.rdelay) begin
            i_din = 1'($urandom_range(1));
            cycle();
            checkw("hold_dout", ov_dout, v.exp_dout);
            checkb("hold_ready", o_ready, 1'b0);
        end
        checkw("word", ov_dout, v.exp_dout);
        checkb("word_perr", o_parity_err, v.exp_perr);
        i_ready     = 1'b1;
        i_din_valid = 1'b0;
        cycle();
        checkb("released_valid", o_dout_valid, 1'b0);
        checkb("released_ready", o_ready, 1'b1);
        i_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic [L-1:0] w, input logic p, input int duty,
                                input int rd, input int en_at, input logic en_out);
        vec_t v;
        v.word = w; v.par = p; v.duty = duty; v.rdelay = rd;
        v.en_at = en_at; v.en_out = en_out; v.exp_dout = w;
`ifdef DESER_PARITY_EN
        v.exp_perr = (^w) ^ p;
`else
        v.exp_perr = 1'b0;
`endif
        return v;
    endfunction

    initial begin
        vec_t v;
        i_rst = 1'b1; i_en = 1'b1; i_din = 1'b0; i_din_valid = 1'b0; i_ready = 1'b0;
        model_reset();
        @(negedge i_clk);
        checkb("init_ready", o_ready, 1'b0);
        checkb("init_valid", o_dout_valid, 1'b0);
        checkw("init_dout", ov_dout, '0);
        checkb("init_perr", o_parity_err, 1'b0);
        @(posedge i_clk);
        #3 i_rst = 1'b0;

        // Directed vector table.
        vecs.push_back(mk(24'hA5C3F1, 1'b0, 100, 0, -1, 1'b0));
        vecs.push_back(mk(24'h5A3C0F, 1'b0, 100, 7, -1, 1'b0));
        vecs.push_back(mk(24'h000001, 1'b1, 100, 0, -1, 1'b0));
        vecs.push_back(mk(24'h123456, 1'b0, 100, 2, 12, 1'b1));
        vecs.push_back(mk(24'hFFFFFF, 1'b0,  50, 1, -1, 1'b0));
        vecs.push_back(mk(24'h000000, 1'b0,  50, 0, -1, 1'b0));
`ifdef DESER_PARITY_EN
        vecs.push_back(mk(24'h000003, 1'b0, 100, 0, -1, 1'b0));
        vecs.push_back(mk(24'h000007, 1'b0, 100, 0, -1, 1'b0));
`endif
        foreach (vecs[i]) send_word(vecs[i]);

        // Reset mid-word after 10 bits, then a clean word.
        feed_bits(24'hFFFFFF, 10);
        reset_pulse();
        send_word(mk(24'h0F0F0F, 1'b1, 100, 0, -1, 1'b0));

        // Reset while a word is held.
        feed_bits(24'hABCDEF, NBITS);
        checkb("out_before_reset", o_dout_valid, 1'b1);
        reset_pulse();
        send_word(mk(24'h800001, 1'b0, 100, 1, -1, 1'b0));

        // Randomized words.
        for (int n = 0; n < 25; n++) begin
            v = mk(24'($urandom), 1'($urandom_range(1)), int'($urandom_range(100, 30)),
                   int'($urandom_range(4)),
                   ($urandom_range(3) == 0) ? int'($urandom_range(L - 1)) : -1,
                   1'($urandom_range(3) == 0));
            send_word(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
